uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART_TX instance between NREQ byte requesters. It owns the transmitter's Transmit, DataTx and clr_tx_flag inputs. It sequences one frame at a time, waits for endTx_flag, then clears the flag and acknowledges the requester. It sits between the processor-side peripherals (debug print, register dump, status reporter) and the single serial pin.

## Interface
Parameters:
- Nbit, 8, frame data width; must match UART_TX.
- NREQ, 4, number of requesters, 2..8.
- TIMEOUT_CYCLES, 4096, WAIT watchdog limit; used only when the watchdog is compiled in.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- req  in  NREQ  per-requester request level; held high until ack.
- req_data  in  NREQ*Nbit  requester i's byte at bits [i*Nbit +: Nbit].
- ack  out  NREQ  one-cycle pulse to the served requester after its frame completes.
- tmo_err  out  NREQ  one-cycle pulse to the served requester on watchdog abort.
- busy  out  1  high in every state except IDLE.
- active_id  out  $clog2(NREQ)  index of the requester being served; holds its last value in IDLE.
- Transmit  out  1  to UART_TX; one-cycle start pulse.
- DataTx  out  Nbit  to UART_TX; byte latched at grant, stable until the next grant.
- clr_tx_flag  out  1  to UART_TX; one-cycle pulse that clears endTx_flag.
- endTx_flag  in  1  from UART_TX; sticky frame-done flag.

## Operation
- States: IDLE, LOAD, WAIT, CLEAR. All outputs are registered.
- Reset values: state=IDLE; Transmit, clr_tx_flag, ack, tmo_err, busy = 0; DataTx=0; active_id=0; rr pointer=NREQ-1, so requester 0 wins first.
- IDLE: if any req bit is high, pick the first high bit searching upward from pointer+1 with wrap. Latch active_id and DataTx<=req_data[id], set pointer<=id, go to LOAD. If no req bit is high, stay in IDLE.
- LOAD: Transmit=1 for exactly this cycle. endTx_flag is ignored here. Go to WAIT.
- WAIT: on sampling endTx_flag=1, go to CLEAR with ack[id] scheduled.
- CLEAR: clr_tx_flag=1 and ack[id]=1 (or tmo_err[id]=1 on abort) for exactly this cycle. Go to IDLE.
- Requester deassertion: a requester that drops req during LOAD or WAIT does not cancel the frame. The frame completes and ack is still pulsed.
- Data changes: changes to req_data after the grant are ignored.
- Fairness: a requester holding req continuously is re-served only after every other pending requester has been served once.
- Requests arriving in a non-IDLE state wait; none are lost as long as req is held.

## Timing
- Grant latency: req sampled high in IDLE at edge N gives LOAD (Transmit=1) in cycle N+1 and WAIT from N+2.
- Completion: endTx_flag sampled high at edge M gives CLEAR (ack, clr_tx_flag) in cycle M+1 and IDLE in M+2.
- Earliest next grant: Transmit at M+3. Back-to-back frames are therefore separated by 3 cycles of overhead plus the UART frame time.
- Requester deassertion: a requester that deasserts req on the edge after seeing ack is not re-granted.
- Reset mid-frame: outputs return to reset values immediately. The UART's own reset clears its state.

## Configuration
- UART_TX_ARB_TIMEOUT_EN defined: a cycle counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles elapse without endTx_flag, go to CLEAR.
  - In CLEAR, pulse clr_tx_flag and tmo_err[id], with no ack.
  - The pointer still advances.
- UART_TX_ARB_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; tmo_err is tied to 0.

## Structure
- Package uart_tx_arb_pkg holds the state encoding (IDLE=2'd0, LOAD=2'd1, WAIT=2'd2, CLEAR=2'd3) and the default parameter constants.
- Sub-module rr_pick: combinational rotate-and-priority-encode. Inputs: req and pointer. Outputs: a valid bit and the winning index.

## Test plan
- Reset with req=4'b0000 → all outputs 0, busy=0, no Transmit pulse over 100 cycles.
- req[2]=1, data=8'h55, UART model asserts endTx_flag 200 cycles after Transmit:
  - Transmit pulses once, 1 cycle after req.
  - DataTx=8'h55.
  - ack[2] and clr_tx_flag pulse together.
  - busy falls 2 cycles after endTx_flag.
- req=4'b1111 held, data 8'hA0..8'hA3 → service order 0,1,2,3,0. Consecutive Transmit pulses are separated by frame time + 3 cycles.
- req[1] dropped during WAIT and req_data[1] changed → frame completes with the original byte and ack[1] still pulses.
- Reset asserted during WAIT → Transmit, clr_tx_flag and busy go to 0 immediately. After release, requester 0 is granted first.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, endTx_flag never asserted:
  - tmo_err[id] and clr_tx_flag pulse 64 cycles into WAIT; no ack.
  - The next pending requester is granted.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// default parameter values.
package uart_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      WAIT  = 2'd2,
      CLEAR = 2'd3
   } arb_state_e;

   localparam int NBIT_DEF    = 8;
   localparam int NREQ_DEF    = 4;
   localparam int TIMEOUT_DEF = 4096;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: finds the first set request bit searching upward from
// ptr+1 with wrap-around. Purely combinational.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic            valid,
   output logic [IDW-1:0]  idx
);

   function automatic int wrap_idx(input int base, input int k);
      int c;
      c = base + k;
      return (c >= NREQ) ? c - NREQ : c;
   endfunction

   // Walk from the farthest candidate to the nearest so the nearest match wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[IDW'(wrap_idx(int'(ptr), k))]) begin
            valid = 1'b1;
            idx   = IDW'(wrap_idx(int'(ptr), k));
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART_TX between NREQ byte requesters.
// Optional WAIT watchdog compiled in with UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int Nbit           = NBIT_DEF,
   parameter int NREQ           = NREQ_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*Nbit-1:0]     req_data,
   output logic [NREQ-1:0]          ack,
   output logic [NREQ-1:0]          tmo_err,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  active_id,
   output logic                     Transmit,
   output logic [Nbit-1:0]          DataTx,
   output logic                     clr_tx_flag,
   input  logic                     endTx_flag,
   output arb_state_e               state_dbg
);

   localparam int IDW = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES >= 2");
   end

   arb_state_e      state, next_state;
   logic [IDW-1:0]  ptr;
   logic            pick_valid;
   logic [IDW-1:0]  pick_idx;
   logic            timeout_hit;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign state_dbg = state;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (pick_valid) next_state = LOAD;
         LOAD:    next_state = WAIT;
         WAIT:    if (endTx_flag || timeout_hit) next_state = CLEAR;
         CLEAR:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from next_state so each pulse lines up with its state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ptr         <= IDW'(NREQ - 1);
         active_id   <= '0;
         DataTx      <= '0;
         Transmit    <= 1'b0;
         clr_tx_flag <= 1'b0;
         busy        <= 1'b0;
         ack         <= '0;
      end else begin
         state       <= next_state;
         Transmit    <= (next_state == LOAD);
         clr_tx_flag <= (next_state == CLEAR);
         busy        <= (next_state != IDLE);
         ack         <= '0;
         if (state == WAIT && endTx_flag) ack[active_id] <= 1'b1;
         if (state == IDLE && pick_valid) begin
            active_id <= pick_idx;
            ptr       <= pick_idx;
            DataTx    <= req_data[pick_idx*Nbit +: Nbit];
         end
      end
   end

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] wait_cnt;

   // Counter is zero on the first WAIT edge; abort fires on its TIMEOUT_CYCLES-th edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
         tmo_err  <= '0;
      end else begin
         wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         tmo_err  <= '0;
         if (state == WAIT && !endTx_flag && timeout_hit) tmo_err[active_id] <= 1'b1;
      end
   end

   assign timeout_hit = (state == WAIT) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
   assign tmo_err     = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the UART is modelled inline by raising
// endTx_flag a chosen number of cycles after Transmit.
module tb_uart_tx_arbiter;

   localparam int NB = 8;
   localparam int NR = 4;
`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int TMO = 64;
`else
   localparam int TMO = 4096;
`endif
   localparam int LONG_FRAME = (TMO > 250) ? 200 : TMO / 2;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [NR-1:0]  req = '0;
   logic [NR*NB-1:0] req_data = '0;
   logic           endTx_flag = 1'b0;
   logic [NR-1:0]  ack, tmo_err;
   logic           busy, Transmit, clr_tx_flag;
   logic [1:0]     active_id;
   logic [NB-1:0]  DataTx;
   uart_tx_arb_pkg::arb_state_e state_dbg;

   int errors = 0;
   int checks = 0;

   uart_tx_arbiter #(.Nbit(NB), .NREQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .tmo_err     (tmo_err),
      .busy        (busy),
      .active_id   (active_id),
      .Transmit    (Transmit),
      .DataTx      (DataTx),
      .clr_tx_flag (clr_tx_flag),
      .endTx_flag  (endTx_flag),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic reset_dut();
      reset = 1'b0; req = '0; req_data = '0; endTx_flag = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic wait_transmit(input int limit, output int waited);
      waited = 0;
      while (Transmit !== 1'b1 && waited < limit) begin
         tick();
         waited++;
      end
      if (Transmit !== 1'b1) waited = -1;
   endtask

   // Called on the Transmit cycle; returns on the CLEAR cycle.
   task automatic finish_frame(input int frame);
      repeat (frame) tick();
      endTx_flag = 1'b1;
      tick();
      endTx_flag = 1'b0;
   endtask

   task automatic test_reset();
      int tx_cnt, busy_cnt;
      reset = 1'b0; req = '0; req_data = '0; endTx_flag = 1'b0;
      tick(); tick();
      checks++; if (Transmit !== 1'b0) begin errors++; $display("FAIL rst_transmit got=%b want=0", Transmit); end
      checks++; if (clr_tx_flag !== 1'b0) begin errors++; $display("FAIL rst_clr got=%b want=0", clr_tx_flag); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack got=%b want=0000", ack); end
      checks++; if (tmo_err !== 4'b0000) begin errors++; $display("FAIL rst_tmo got=%b want=0000", tmo_err); end
      checks++; if (DataTx !== 8'h00) begin errors++; $display("FAIL rst_data got=%h want=00", DataTx); end
      checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL rst_id got=%0d want=0", active_id); end
      reset = 1'b1;
      tx_cnt = 0; busy_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (Transmit === 1'b1) tx_cnt++;
         if (busy !== 1'b0) busy_cnt++;
      end
      checks++; if (tx_cnt != 0) begin errors++; $display("FAIL idle_transmit got=%0d want=0", tx_cnt); end
      checks++; if (busy_cnt != 0) begin errors++; $display("FAIL idle_busy got=%0d want=0", busy_cnt); end
   endtask

   task automatic test_single_frame();
      int tx_cnt;
      req_data[23:16] = 8'h55;
      req = 4'b0100;
      tick();
      checks++; if (Transmit !== 1'b1) begin errors++; $display("FAIL grant_latency transmit got=%b want=1", Transmit); end
      checks++; if (DataTx !== 8'h55) begin errors++; $display("FAIL single_data got=%h want=55", DataTx); end
      checks++; if (active_id !== 2'd2) begin errors++; $display("FAIL single_id got=%0d want=2", active_id); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b want=1", busy); end
      tick();
      checks++; if (Transmit !== 1'b0) begin errors++; $display("FAIL single_pulse got=%b want=0", Transmit); end
      finish_frame(LONG_FRAME - 1);
      checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack got=%b want=0100", ack); end
      checks++; if (clr_tx_flag !== 1'b1) begin errors++; $display("FAIL single_clr got=%b want=1", clr_tx_flag); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_clear got=%b want=1", busy); end
      req = 4'b0000;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%b want=0", busy); end
      checks++; if (ack !== 4'b0000 || clr_tx_flag !== 1'b0) begin errors++; $display("FAIL single_pulse_end got=%b/%b want=0000/0", ack, clr_tx_flag); end
      tx_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (Transmit === 1'b1) tx_cnt++;
      end
      checks++; if (tx_cnt != 0) begin errors++; $display("FAIL no_regrant got=%0d want=0", tx_cnt); end
   endtask

   task automatic test_round_robin();
      int exp_ids[5] = '{0, 1, 2, 3, 0};
      int frames[5]  = '{20, 33, 17, 25, 40};
      int waited, exp_wait;
      logic [3:0] exp_ack;
      logic [7:0] exp_data;
      reset_dut();
      for (int i = 0; i < NR; i++) req_data[i*NB +: NB] = 8'hA0 + 8'(i);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_wait = (k == 0) ? 1 : 2;
         wait_transmit(10, waited);
         checks++; if (waited != exp_wait) begin errors++; $display("FAIL rr_gap[%0d] got=%0d want=%0d", k, waited, exp_wait); end
         checks++; if (active_id !== 2'(exp_ids[k])) begin errors++; $display("FAIL rr_id[%0d] got=%0d want=%0d", k, active_id, exp_ids[k]); end
         exp_data = 8'hA0 + 8'(exp_ids[k]);
         checks++; if (DataTx !== exp_data) begin errors++; $display("FAIL rr_data[%0d] got=%h want=%h", k, DataTx, exp_data); end
         finish_frame(frames[k]);
         exp_ack = 4'b0001 << exp_ids[k];
         checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d] got=%b want=%b", k, ack, exp_ack); end
         if (k == 4) req = 4'b0000;
      end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle got=%b want=0", busy); end
   endtask

   task automatic test_drop_during_wait();
      int waited;
      req_data[15:8] = 8'h3C;
      req = 4'b0010;
      wait_transmit(10, waited);
      checks++; if (waited != 1) begin errors++; $display("FAIL drop_grant got=%0d want=1", waited); end
      checks++; if (active_id !== 2'd1) begin errors++; $display("FAIL drop_id got=%0d want=1", active_id); end
      repeat (5) tick();
      req = 4'b0000;
      req_data[15:8] = 8'hC3;
      tick();
      checks++; if (DataTx !== 8'h3C) begin errors++; $display("FAIL drop_data got=%h want=3c", DataTx); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy got=%b want=1", busy); end
      finish_frame(24);
      checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL drop_ack got=%b want=0010", ack); end
      checks++; if (clr_tx_flag !== 1'b1) begin errors++; $display("FAIL drop_clr got=%b want=1", clr_tx_flag); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle got=%b want=0", busy); end
   endtask

   task automatic test_reset_mid_frame();
      int waited;
      req_data[23:16] = 8'h77;
      req = 4'b0100;
      wait_transmit(10, waited);
      checks++; if (active_id !== 2'd2) begin errors++; $display("FAIL mid_pre_id got=%0d want=2", active_id); end
      repeat (10) tick();
      reset = 1'b0;
      #1;
      checks++; if (Transmit !== 1'b0) begin errors++; $display("FAIL mid_transmit got=%b want=0", Transmit); end
      checks++; if (clr_tx_flag !== 1'b0) begin errors++; $display("FAIL mid_clr got=%b want=0", clr_tx_flag); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b want=0", busy); end
      checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL mid_id got=%0d want=0", active_id); end
      checks++; if (DataTx !== 8'h00) begin errors++; $display("FAIL mid_data got=%h want=00", DataTx); end
      tick();
      req_data[7:0]   = 8'h11;
      req_data[31:24] = 8'h99;
      req = 4'b1001;
      reset = 1'b1;
      wait_transmit(10, waited);
      checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL post_rst_id got=%0d want=0", active_id); end
      checks++; if (DataTx !== 8'h11) begin errors++; $display("FAIL post_rst_data got=%h want=11", DataTx); end
      finish_frame(10);
      checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL post_rst_ack got=%b want=0001", ack); end
      req = 4'b1000;
      wait_transmit(10, waited);
      checks++; if (active_id !== 2'd3 || DataTx !== 8'h99) begin errors++; $display("FAIL post_rst_next got=%0d/%h want=3/99", active_id, DataTx); end
      finish_frame(10);
      checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL post_rst_ack2 got=%b want=1000", ack); end
      req = 4'b0000;
      tick();
   endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int waited, n;
      reset_dut();
      req_data[7:0]  = 8'hE0;
      req_data[15:8] = 8'hE1;
      req = 4'b0011;
      wait_transmit(10, waited);
      checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL tmo_first_id got=%0d want=0", active_id); end
      n = 0;
      while (tmo_err === 4'b0000 && n < 200) begin
         tick();
         n++;
      end
      checks++; if (n != TMO + 1) begin errors++; $display("FAIL tmo_latency got=%0d want=%0d", n, TMO + 1); end
      checks++; if (tmo_err !== 4'b0001) begin errors++; $display("FAIL tmo_err got=%b want=0001", tmo_err); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL tmo_no_ack got=%b want=0000", ack); end
      checks++; if (clr_tx_flag !== 1'b1) begin errors++; $display("FAIL tmo_clr got=%b want=1", clr_tx_flag); end
      req = 4'b0010;
      wait_transmit(10, waited);
      checks++; if (waited != 2 || active_id !== 2'd1) begin errors++; $display("FAIL tmo_next got=%0d/%0d want=2/1", waited, active_id); end
      finish_frame(10);
      checks++; if (ack !== 4'b0010 || tmo_err !== 4'b0000) begin errors++; $display("FAIL tmo_next_ack got=%b/%b want=0010/0000", ack, tmo_err); end
      req = 4'b0000;
      tick();
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_frame();
      test_round_robin();
      test_drop_during_wait();
      test_reset_mid_frame();
`ifdef UART_TX_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
